// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared parity encodings, FSM state type and sizing helper for UART.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_cnt
// Brief   : Bit-period counter with phase restart and an end-of-bit tick.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int                CNT_W   = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = en && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame
// Brief   : UART transmitter with framed baud timing and one-entry hold buffer.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int               CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int               IDX_W        = clog2((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA    = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP    = IDX_W'(STOP_BITS - 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] hold_d;
  logic [DATA_BITS-1:0] load_data;
  logic                 hold_full_q;
  logic                 hold_full_d;
  logic                 par_q;
  logic                 par_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 load;
  logic                 bypass;
  logic                 bit_end;
  logic                 frame_end;
  logic                 enter_start;
  logic                 baud_en;

  assign in_ready  = ~hold_full_q;
  assign accept    = in_valid & in_ready;
  assign frame_end = (state_q == ST_STOP) && bit_end && (idx_q == LAST_STOP);
  assign baud_en   = (state_q != ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (enter_start),
    .en      (baud_en),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    bypass      = 1'b0;
    load_data   = hold_q;
    tx_d        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q != LAST_STOP) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (hold_full_q) begin
            state_d = ST_START;
            load    = 1'b1;
          end else if (accept) begin
            // A byte arriving exactly at frame end skips the hold register.
            state_d   = ST_START;
            load      = 1'b1;
            bypass    = 1'b1;
            load_data = in_data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d     = load_data;
      par_d       = (PARITY == PAR_EVEN) ? ^load_data : ~^load_data;
      hold_full_d = 1'b0;
    end
    if (accept && !bypass) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  assign enter_start = (state_d == ST_START) && (state_q != ST_START);

  // Line outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      busy_q      <= (state_q != ST_IDLE);
      done_q      <= frame_end;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_frame
// Brief   : Self-checking bench for uart_tx_frame (8N1, 7O2 and 7E2 instances).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [2:0][8:0] din   = '0;
  logic [2:0]      vld   = '0;
  logic [2:0]      tx_w;
  logic [2:0]      rdy_w;
  logic [2:0]      busy_w;
  logic [2:0]      done_w;

  int n_checks  = 0;
  int n_fail    = 0;
  int acc_total = 0;
  int frame_cnt = 0;
  int done_cnt  = 0;
  int mon_j     = -1;
  logic [8:0] mon_d = '0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy_w[0]),
    .tx_out(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1][6:0]), .in_valid(vld[1]), .in_ready(rdy_w[1]),
    .tx_out(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .in_data(din[2][6:0]), .in_valid(vld[2]), .in_ready(rdy_w[2]),
    .tx_out(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dbits_of(input int idx); return (idx == 0) ? 8 : 7; endfunction
  function automatic int par_of(input int idx);   return idx;                endfunction
  function automatic int stop_of(input int idx);  return (idx == 0) ? 1 : 2; endfunction
  function automatic int frame_len(input int idx);
    return (1 + dbits_of(idx) + ((par_of(idx) != 0) ? 1 : 0) + stop_of(idx)) * CPB;
  endfunction

  // Line level of bit slot b of a frame: start, data LSB-first, optional parity, stop ones.
  function automatic logic frame_bit(input logic [8:0] d, input int dbits, input int par, input int b);
    int ones;
    ones = 0;
    for (int i = 0; i < dbits; i++) ones += (d[i] ? 1 : 0);
    if (b == 0) return 1'b0;
    if (b <= dbits) return d[b-1];
    if (par != 0 && b == dbits + 1) return (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  // Scoreboard for the 8N1 instance: accepted bytes in, decoded line frames out.
  always @(posedge clk) begin
    if (rst_n && vld[0] && rdy_w[0]) begin
      exp_q.push_back(din[0][7:0]);
      acc_total++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_j = -1;
      exp_q.delete();
    end else begin
      if (mon_j < 0 && tx_w[0] == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_frame", 1, 0);
          mon_d = '0;
        end else begin
          mon_d = {1'b0, exp_q.pop_front()};
        end
        mon_j = 0;
      end
      if (mon_j >= 0) begin
        chk("mon_tx", tx_w[0], frame_bit(mon_d, 8, 0, mon_j / CPB));
        chk("mon_busy", busy_w[0], 1);
        chk("mon_done", done_w[0], mon_j == 39);
        if (done_w[0]) done_cnt++;
        if (mon_j == 39) begin
          frame_cnt++;
          mon_j = -1;
        end else begin
          mon_j = mon_j + 1;
        end
      end else begin
        chk("mon_idle_busy", busy_w[0], 0);
        chk("mon_idle_done", done_w[0], 0);
      end
    end
  end

  task automatic wait_idle(input int idx);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy_w[idx] || !rdy_w[idx]) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("wait_idle", busy_w[idx] || !rdy_w[idx], 0);
  endtask

  task automatic send_check(input int idx, input logic [8:0] d, output int obs_len, output logic obs_par);
    int dbits, par, len, g;
    dbits = dbits_of(idx);
    par   = par_of(idx);
    len   = frame_len(idx);
    g     = 0;
    @(negedge clk);
    while (!rdy_w[idx] && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("ready_before_send", rdy_w[idx], 1);
    din[idx] = d;
    vld[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[idx] = 1'b0;
    chk("ready_low_after_accept", rdy_w[idx], 0);
    chk("tx_idle_k", tx_w[idx], 1);
    @(negedge clk);
    chk("tx_idle_k1", tx_w[idx], 1);
    obs_len = 0;
    obs_par = 1'b0;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (j == 0) chk("ready_high_k2", rdy_w[idx], 1);
      chk("frame_tx", tx_w[idx], frame_bit(d, dbits, par, j / CPB));
      chk("frame_done", done_w[idx], j == len - 1);
      if (busy_w[idx]) obs_len++;
      if (j == (dbits + 1) * CPB + 1) obs_par = tx_w[idx];
    end
    @(negedge clk);
    chk("idle_after_busy", busy_w[idx], 0);
    chk("idle_after_tx", tx_w[idx], 1);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t       vt[9];
  logic [7:0] tartz[5];
  int         olen;
  logic       opar;
  int         n_acc, meas_run, meas_guard, done0, frame0, acc0;
  logic       b2b_r;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", tx_w[i], 1);
      chk("reset_ready", rdy_w[i], 1);
      chk("reset_busy", busy_w[i], 0);
      chk("reset_done", done_w[i], 0);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    vt[0] = '{0, 9'h054, 40, 1'b0};
    vt[1] = '{0, 9'h0FF, 40, 1'b0};
    vt[2] = '{0, 9'h000, 40, 1'b0};
    vt[3] = '{1, 9'h061, 44, 1'b0};
    vt[4] = '{2, 9'h061, 44, 1'b1};
    vt[5] = '{1, 9'h07F, 44, 1'b0};
    vt[6] = '{1, 9'h000, 44, 1'b1};
    vt[7] = '{2, 9'h000, 44, 1'b0};
    vt[8] = '{2, 9'h015, 44, 1'b1};
    for (int i = 0; i < 9; i++) begin
      send_check(vt[i].inst, vt[i].data, olen, opar);
      chk("vec_len", olen, vt[i].exp_len);
      if (vt[i].inst != 0) chk("vec_parity", opar, vt[i].exp_par);
    end

    // Back-to-back "Tartz" with in_valid held high.
    tartz = '{8'h54, 8'h61, 8'h72, 8'h74, 8'h7A};
    wait_idle(0);
    n_acc    = 0;
    meas_run = 0;
    done0    = done_cnt;
    fork
      begin
        @(negedge clk);
        din[0] = {1'b0, tartz[0]};
        vld[0] = 1'b1;
        for (int g = 0; g < 400 && n_acc < 5; g++) begin
          b2b_r = rdy_w[0];
          @(posedge clk);
          @(negedge clk);
          if (b2b_r) begin
            n_acc++;
            chk("b2b_ready_low_when_full", rdy_w[0], 0);
            if (n_acc < 5) din[0] = {1'b0, tartz[n_acc]};
            else vld[0] = 1'b0;
          end
        end
      end
      begin
        @(negedge clk);
        meas_guard = 0;
        while (!busy_w[0] && meas_guard < 100) begin
          @(negedge clk);
          meas_guard++;
        end
        while (busy_w[0] && meas_run < 400) begin
          meas_run++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_accepts", n_acc, 5);
    chk("b2b_contiguous_cycles", meas_run, 200);
    chk("b2b_done_pulses", done_cnt - done0, 5);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Handshake on the last stop cycle with an empty hold register.
    wait_idle(0);
    @(negedge clk);
    din[0] = 9'h03C;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    din[0] = 9'h0C3;
    vld[0] = 1'b1;
    chk("bypass_ready_before", rdy_w[0], 1);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    chk("bypass_ready_stays_high", rdy_w[0], 1);
    chk("bypass_done_first", done_w[0], 1);
    @(negedge clk);
    chk("bypass_no_gap_tx", tx_w[0], 0);
    chk("bypass_no_gap_busy", busy_w[0], 1);
    wait_idle(0);
    chk("bypass_queue_empty", exp_q.size(), 0);

    // Random valid and data toggling under back-pressure.
    acc0   = acc_total;
    frame0 = frame_cnt;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (acc_total - acc0 >= 12) break;
      vld[0] = ($urandom_range(0, 3) != 0);
      din[0] = 9'($urandom);
    end
    vld[0] = 1'b0;
    chk("rand_accepts", acc_total - acc0, 12);
    wait_idle(0);
    chk("rand_frames", frame_cnt - frame0, 12);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Reset during data bit 3 of 0x55, then a clean 0xA5 frame.
    @(negedge clk);
    din[0] = 9'h055;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_reset_tx_bit3", tx_w[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx", tx_w[0], 1);
    chk("midreset_ready", rdy_w[0], 1);
    chk("midreset_busy", busy_w[0], 0);
    chk("midreset_done", done_w[0], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send_check(0, 9'h0A5, olen, opar);
    chk("post_reset_len", olen, 40);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
